// File: rtl/transmitter_if.sv
// Write-side and line-side signals of the UART transmitter.
// The producer uses the master modport and the transmitter uses the slave modport.
interface transmitter_if;
  logic       send;
  logic [7:0] send_data;
  logic       full;
  logic       busy;
  logic       dropped;
  logic       out;

  modport master (output send, output send_data,
                  input full, input busy, input dropped, input out);
  modport slave  (input send, input send_data,
                  output full, output busy, output dropped, output out);
endinterface

// File: rtl/transmitter.sv
// 8N1 UART transmitter fed by a circular byte FIFO.
// Queued frames go out back-to-back, LSB first, and the line output is registered.
module transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic          clock,
  input  logic          reset,
  transmitter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int                  CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]    BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [7:0]            mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  push, pop;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shift, shift_n;
  logic              out_q, out_n;
  logic              dropped_q;
  logic              bit_end;

  // The full check uses the pre-edge count, so a pop on the same edge does not make room.
  assign push    = bus.send && (count != DEPTH);
  assign bit_end = (bit_cnt == BIT_LAST);

  // NOTE: the storage array has no reset. Emptying the FIFO only needs the pointers
  // and count cleared, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.send_data;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop samples
  // pre-edge values no matter what order the statements appear in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
      dropped_q <= bus.send && (count == DEPTH);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      out_q   <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      out_q   <= out_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (count != '0) begin
            pop       = 1'b1;
            shift_n   = mem[rd_ptr];
            bit_idx_n = '0;
            state_n   = START;
          end else begin
            state_n   = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // The line level is decoded from the next state, so out changes on the same edge as the state.
    case (state_n)
      START:   out_n = 1'b0;
      DATA:    out_n = shift_n[bit_idx_n];
      default: out_n = 1'b1;
    endcase
  end

  assign bus.out     = out_q;
  assign bus.dropped = dropped_q;
  assign bus.full    = (count == DEPTH);
  assign bus.busy    = (state != IDLE) || (count != '0);

endmodule
